// File: rtl/debounce_pkg.sv
// Shared types and parameter defaults for the debounce/edge-detect block.
package debounce_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 4;

  typedef enum logic [1:0] {
    S_LOW,
    S_CHK_HIGH,
    S_HIGH,
    S_CHK_LOW
  } db_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous level; q_o is the last stage.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[DEPTH-2:0], d_i};
  end

  assign q_o = r_sync[DEPTH-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronizes and debounces a bouncing level, emitting registered rise/fall pulses.
//   state      | meaning
//   S_LOW      | stable low, waiting for sync=1
//   S_CHK_HIGH | qualifying a candidate rise, cnt = high samples seen
//   S_HIGH     | stable high, waiting for sync=0
//   S_CHK_LOW  | qualifying a candidate fall, cnt = low samples seen
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int             CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic          w_sync;
  db_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_stable, w_stable_nxt;
  logic          r_rise, w_rise_nxt;
  logic          r_fall, w_fall_nxt;

  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (raw_i),
    .q_o   (w_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_LOW;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
    end
  end

  // The qualifying sample that enters a CHK state counts as the first of DB_CYCLES.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    case (r_state)
      S_LOW: begin
        if (w_sync) begin
          w_state_nxt = S_CHK_HIGH;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_CHK_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_HIGH;
          w_cnt_nxt    = '0;
          w_stable_nxt = 1'b1;
          w_rise_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = S_CHK_LOW;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_CHK_LOW: begin
        if (w_sync) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_LOW;
          w_cnt_nxt    = '0;
          w_stable_nxt = 1'b0;
          w_fall_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign stable_o = r_stable;
  assign rise_o   = r_rise;
  assign fall_o   = r_fall;
  assign busy_o   = (r_state == S_CHK_HIGH) || (r_state == S_CHK_LOW);

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: directed pulse-timing scoreboard on a default instance,
// plus a run-length reference model checked every cycle on DB_CYCLES = 4, 2 and 8.
module tb_debounce_edge;

  localparam int SYNC = 2;
  localparam int DB0  = 4;
  localparam int DBV [3] = '{DB0, 2, 8};

  typedef struct {
    bit rise;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       raw_d = 1'b1;
  logic       raw_r = 1'b0;
  logic [2:0] st, ri, fa, bu;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  ev_t  exp_q[$];

  logic [1:0] m_syn [3];
  logic       m_st  [3];
  logic       m_ri  [3];
  logic       m_fa  [3];
  int         m_run [3];
  logic [2:0] p_st = '0;

  always #5 clk = ~clk;

  debounce_edge #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB0)) u_dut0 (
    .clk(clk), .reset(reset), .raw_i(raw_d),
    .stable_o(st[0]), .rise_o(ri[0]), .fall_o(fa[0]), .busy_o(bu[0]));
  debounce_edge #(.SYNC_STAGES(SYNC), .DB_CYCLES(DBV[1])) u_dut1 (
    .clk(clk), .reset(reset), .raw_i(raw_r),
    .stable_o(st[1]), .rise_o(ri[1]), .fall_o(fa[1]), .busy_o(bu[1]));
  debounce_edge #(.SYNC_STAGES(SYNC), .DB_CYCLES(DBV[2])) u_dut2 (
    .clk(clk), .reset(reset), .raw_i(raw_r),
    .stable_o(st[2]), .rise_o(ri[2]), .fall_o(fa[2]), .busy_o(bu[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Pulse for a change driven now lands on edge E0 + SYNC + DB - 1, with E0 = next edge.
  task automatic expect_edge(input bit rise);
    ev_t e;
    e.rise = rise;
    e.cyc  = cyc + 1 + SYNC + DB0 - 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a level differing from the accepted one must persist DB samples in a row.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        m_syn[k] <= '0;
        m_st[k]  <= 1'b0;
        m_ri[k]  <= 1'b0;
        m_fa[k]  <= 1'b0;
        m_run[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_syn[k] <= {m_syn[k][0], (k == 0) ? raw_d : raw_r};
        m_ri[k]  <= 1'b0;
        m_fa[k]  <= 1'b0;
        if (m_syn[k][1] != m_st[k]) begin
          if (m_run[k] + 1 >= DBV[k]) begin
            m_st[k]  <= m_syn[k][1];
            m_ri[k]  <= m_syn[k][1];
            m_fa[k]  <= ~m_syn[k][1];
            m_run[k] <= 0;
          end else begin
            m_run[k] <= m_run[k] + 1;
          end
        end else begin
          m_run[k] <= 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    ev_t ev;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stable%0d", k), st[k], m_st[k]);
      chk($sformatf("rise%0d", k),   ri[k], m_ri[k]);
      chk($sformatf("fall%0d", k),   fa[k], m_fa[k]);
      chk($sformatf("busy%0d", k),   bu[k], m_run[k] != 0);
      chk($sformatf("dual_pulse%0d", k), ri[k] & fa[k], 1'b0);
      chk($sformatf("rise_vs_stable%0d", k), ri[k], st[k] & ~p_st[k]);
      chk($sformatf("fall_vs_stable%0d", k), fa[k], ~st[k] & p_st[k]);
      p_st[k] = st[k];
    end
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      ev = exp_q.pop_front();
      chk("sb_rise", ri[0], ev.rise);
      chk("sb_fall", fa[0], !ev.rise);
    end else begin
      chk("sb_unexpected_pulse", ri[0] | fa[0], 1'b0);
    end
  end

  initial begin
    logic bsy;
    int   total;
    int   hold;

    // Reset held two cycles with raw high; outputs must stay 0, then a normal rise.
    wait_cyc(2);
    chk("rst_stable", st[0], 1'b0);
    chk("rst_rise",   ri[0], 1'b0);
    chk("rst_fall",   fa[0], 1'b0);
    chk("rst_busy",   bu[0], 1'b0);
    reset = 1'b1;
    expect_edge(1'b1);
    wait_cyc(8);
    chk("after_rst_stable", st[0], 1'b1);

    raw_d = 1'b0;
    expect_edge(1'b0);
    wait_cyc(8);
    chk("fall_stable", st[0], 1'b0);

    // Rising change traced edge by edge from E0.
    raw_d = 1'b1;
    expect_edge(1'b1);
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("trace_busy_E%0d", e),   bu[0], (e >= 2 && e <= 4));
      chk($sformatf("trace_stable_E%0d", e), st[0], (e >= 5));
      chk($sformatf("trace_rise_E%0d", e),   ri[0], (e == 5));
    end
    @(negedge clk);
    raw_d = 1'b0;
    expect_edge(1'b0);
    wait_cyc(10);

    // Bursts shorter than DB_CYCLES must never be accepted.
    bsy = 1'b0;
    for (int r = 0; r < 10; r++) begin
      raw_d = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (i == 2) raw_d = 1'b0;
        @(negedge clk);
        bsy = bsy | bu[0];
        chk("glitch_stable", st[0], 1'b0);
      end
    end
    chk("glitch_busy_seen", bsy, 1'b1);
    wait_cyc(20);

    // Reset asserted between edges during a rising qualification.
    raw_d = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("abort_busy_pre", bu[0], 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_stable", st[0], 1'b0);
    chk("abort_rise",   ri[0], 1'b0);
    chk("abort_fall",   fa[0], 1'b0);
    chk("abort_busy",   bu[0], 1'b0);
    raw_d = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_cyc(12);
    chk("abort_no_rise_stable", st[0], 1'b0);

    // Random bounce on the DB=2 and DB=8 instances.
    total = 0;
    while (total < 200) begin
      raw_r = 1'($urandom_range(0, 1));
      hold  = $urandom_range(1, 12);
      wait_cyc(hold);
      total += hold;
    end
    raw_r = 1'b0;
    wait_cyc(15);

    chk("pending_pulses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
